tour_cmd_sequencer: RTL and testbench

- Hardware replay engine for a stored list of 16-bit Knight commands (cal/move/fanfare opcodes).
- Sits between a local command RAM and the RemoteComm-style send/response interface.
- Issues each command, waits for the transmit handshake, then waits for the positive acknowledge. Retries or flags an error on a NAK or a timeout.
- Generalises one-shot command sending into a parametrised, depth-configurable tour player with continuous and single-step modes.

---
 rtl/tour_pkg.sv | 32 +++
 rtl/tour_cmd_ram.sv | 31 +++
 rtl/tour_cmd_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_tour_cmd_sequencer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the command tour sequencer and its benches.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tour_pkg;

    // Sequencer states; one-cycle states are ISSUE, NEXT, DONE and ERROR.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_SNT  = 3'd2,
        S_WAIT_RESP = 3'd3,
        S_NEXT      = 3'd4,
        S_PAUSE     = 3'd5,
        S_DONE      = 3'd6,
        S_ERROR     = 3'd7
    } seq_state_t;

    // Error codes reported on err_code.
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT = 2'd1;
    localparam logic [1:0] ERR_RETRY   = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

    // Response byte that the Knight returns for an accepted command.
    localparam logic [7:0] DEF_POS_ACK = 8'hA5;

    // Knight opcodes: full calibrate word and the upper nibble of move commands.
    localparam logic [15:0] CAL_GYRO        = 16'h2000;
    localparam logic [3:0]  OP_MOVE         = 4'h4;
    localparam logic [3:0]  OP_MOVE_FANFARE = 4'h5;

endpackage

// File: rtl/tour_cmd_ram.sv
// Single-port DEPTH x CMD_W command store with a registered read port.
// Latency: read data valid one clock after the address is presented.
// Backpressure: none; a write and a read share the one address each cycle.
module tour_cmd_ram
    import tour_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int CMD_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [CMD_W-1:0] wdata_i,
    output logic [CMD_W-1:0] rdata_o
);

    logic [CMD_W-1:0] mem_q [DEPTH];
    logic [CMD_W-1:0] rdata_q;

    // Storage is deliberately not reset; read-first on a same-address write.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tour_cmd_sequencer.sv
// Replays a stored list of Knight commands, retrying on NAK and flagging timeouts.
// Latency: first snd_cmd one clock after start; at least four clocks between commands.
// Backpressure: stalls on cmd_snt and on the response; step_mode pauses between commands.
module tour_cmd_sequencer
    import tour_pkg::*;
#(
    parameter int                DEPTH        = 32,
    parameter int                CMD_W        = 16,
    parameter int                RESP_W       = 8,
    parameter logic [RESP_W-1:0] POS_ACK      = RESP_W'(DEF_POS_ACK),
    parameter int                TIMEOUT_CLKS = 2000000,
    parameter int                MAX_RETRY    = 2,
    localparam int               AW           = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [CMD_W-1:0]  wr_data,
    input  logic [AW:0]       num_cmds,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic              abort,
    output logic [CMD_W-1:0]  cmd,
    output logic              snd_cmd,
    input  logic              cmd_snt,
    input  logic              resp_rdy,
    input  logic [RESP_W-1:0] resp,
    output logic              busy,
    output logic              paused,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [AW-1:0]     cur_idx
);

    localparam int TW = (TIMEOUT_CLKS < 2) ? 1 : $clog2(TIMEOUT_CLKS);
    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    localparam logic [AW:0]   DEPTH_L   = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] TO_MAX    = '1;
    localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

    seq_state_t        state_q,    state_d;
    logic [AW-1:0]     cur_idx_q,  cur_idx_d;
    logic [AW:0]       len_q,      len_d;
    logic [RW-1:0]     retry_q,    retry_d;
    logic [TW-1:0]     tmo_q,      tmo_d;
    logic              err_q,      err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic [CMD_W-1:0]  cmd_q,      cmd_d;

    logic [AW-1:0]     rd_addr;
    logic [AW-1:0]     ram_addr;
    logic              ram_we;
    logic [CMD_W-1:0]  ram_rdata;
    logic              busy_state;
    logic              last_cmd;
    logic              resp_ok;

    // Writes are only honoured while idle and not starting, so the start
    // cycle can use the single port to prefetch entry 0.
    always_comb begin
        ram_we   = (state_q == S_IDLE) && wr_en && !start;
        ram_addr = ram_we ? wr_addr : rd_addr;
    end

    tour_cmd_ram #(
        .DEPTH (DEPTH),
        .CMD_W (CMD_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (wr_data),
        .rdata_o (ram_rdata)
    );

    // State and datapath registers; reset returns every output to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_idx_q  <= '0;
            len_q      <= '0;
            retry_q    <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            cmd_q      <= '0;
        end else begin
            state_q    <= state_d;
            cur_idx_q  <= cur_idx_d;
            len_q      <= len_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            cmd_q      <= cmd_d;
        end
    end

    // Next-state, datapath updates, read address and state-decoded outputs.
    always_comb begin
        state_d    = state_q;
        cur_idx_d  = cur_idx_q;
        len_d      = len_q;
        retry_d    = retry_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        cmd_d      = cmd_q;
        rd_addr    = cur_idx_q;

        busy_state = (state_q == S_ISSUE) || (state_q == S_WAIT_SNT) ||
                     (state_q == S_WAIT_RESP) || (state_q == S_NEXT) ||
                     (state_q == S_PAUSE);
        last_cmd   = ({1'b0, cur_idx_q} == (len_q - (AW + 1)'(1)));
        resp_ok    = (resp == POS_ACK);

        if (abort && busy_state) begin
            // Abort overrides any handshake or response arriving this cycle.
            state_d    = S_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_ABORT;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rd_addr = '0;
                    if (start) begin
                        err_d      = 1'b0;
                        err_code_d = ERR_NONE;
                        cur_idx_d  = '0;
                        retry_d    = '0;
                        tmo_d      = '0;
                        if (num_cmds == '0) begin
                            state_d = S_DONE;
                        end else begin
                            len_d   = (num_cmds > DEPTH_L) ? DEPTH_L : num_cmds;
                            state_d = S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    // Capture the prefetched word so cmd stays put through the wait.
                    cmd_d   = ram_rdata;
                    state_d = S_WAIT_SNT;
                end
                S_WAIT_SNT: begin
                    if (cmd_snt) begin
                        tmo_d   = '0;
                        state_d = S_WAIT_RESP;
                    end
                end
                S_WAIT_RESP: begin
                    // A response on the expiry cycle takes precedence over the timeout.
                    if (resp_rdy) begin
                        if (resp_ok) begin
                            retry_d = '0;
                            if (last_cmd) begin
                                state_d = S_DONE;
                            end else if (step_mode) begin
                                state_d = S_PAUSE;
                            end else begin
                                state_d = S_NEXT;
                            end
                        end else if (retry_q < RETRY_LIM) begin
                            retry_d = retry_q + RW'(1);
                            state_d = S_ISSUE;
                        end else begin
                            state_d    = S_ERROR;
                            err_d      = 1'b1;
                            err_code_d = ERR_RETRY;
                        end
                    end else if (tmo_q == TO_LAST) begin
                        state_d    = S_ERROR;
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                    end else if (tmo_q != TO_MAX) begin
                        tmo_d = tmo_q + TW'(1);
                    end
                end
                S_NEXT: begin
                    cur_idx_d = cur_idx_q + AW'(1);
                    rd_addr   = cur_idx_q + AW'(1);
                    state_d   = S_ISSUE;
                end
                S_PAUSE: begin
                    if (step || !step_mode) begin
                        state_d = S_NEXT;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                S_ERROR: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        snd_cmd = (state_q == S_ISSUE);
        cmd     = (state_q == S_ISSUE) ? ram_rdata : cmd_q;
        busy    = busy_state;
        paused  = (state_q == S_PAUSE);
        done    = (state_q == S_DONE);
    end

    assign err      = err_q;
    assign err_code = err_code_q;
    assign cur_idx  = cur_idx_q;

endmodule

// File: tb/tb_tour_cmd_sequencer.sv
// Directed bench for tour_cmd_sequencer: replay, retry, timeout, step, abort, reset.
// Latency: n/a.
// Backpressure: bench plays the transmitter and responder.
module tb_tour_cmd_sequencer;
    import tour_pkg::*;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [15:0]       wr_data;
    logic [AW:0]       num_cmds;
    logic              start;
    logic              step_mode;
    logic              step;
    logic              abort;
    logic [15:0]       cmd;
    logic              snd_cmd;
    logic              cmd_snt;
    logic              resp_rdy;
    logic [7:0]        resp;
    logic              busy;
    logic              paused;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [AW-1:0]     cur_idx;

    int vectors     = 0;
    int miscompares = 0;
    int snd_cnt     = 0;
    int done_cnt    = 0;
    int s0;
    int d0;

    tour_cmd_sequencer #(
        .DEPTH        (DEPTH),
        .CMD_W        (16),
        .RESP_W       (8),
        .POS_ACK      (8'hA5),
        .TIMEOUT_CLKS (100),
        .MAX_RETRY    (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .num_cmds  (num_cmds),
        .start     (start),
        .step_mode (step_mode),
        .step      (step),
        .abort     (abort),
        .cmd       (cmd),
        .snd_cmd   (snd_cmd),
        .cmd_snt   (cmd_snt),
        .resp_rdy  (resp_rdy),
        .resp      (resp),
        .busy      (busy),
        .paused    (paused),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .cur_idx   (cur_idx)
    );

    always #5 clk = ~clk;

    // Count send strobes and done pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (snd_cmd === 1'b1) snd_cnt <= snd_cnt + 1;
        if (done === 1'b1)    done_cnt <= done_cnt + 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_tour(input logic [AW:0] n);
        num_cmds = n; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait for a send, check the word, then play the transmitter handshake.
    task automatic send_phase(input logic [15:0] exp_cmd, input string tag);
        int n;
        n = 0;
        while (snd_cmd !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, ".snd"}, 32'(snd_cmd), 32'd1);
        chk({tag, ".cmd"}, 32'(cmd), 32'(exp_cmd));
        tick();
        cmd_snt = 1'b1;
        tick();
        cmd_snt = 1'b0;
        chk({tag, ".hold"}, 32'(cmd), 32'(exp_cmd));
    endtask

    task automatic serve(input logic [15:0] exp_cmd, input logic [7:0] r, input string tag);
        send_phase(exp_cmd, tag);
        resp = r; resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; num_cmds = '0;
        start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0;
        cmd_snt = 1'b0; resp_rdy = 1'b0; resp = '0;
        tick(); tick();
        chk("rst.flags", 32'({busy, paused, done, err, err_code, snd_cmd}), 32'd0);
        chk("rst.cmd", 32'(cmd), 32'd0);
        chk("rst.idx", 32'(cur_idx), 32'd0);
        rst = 1'b0;
        tick();

        // Plain three-command tour, all acked.
        load(3'd0, 16'h53F4); load(3'd1, 16'h47F1); load(3'd2, 16'h5BF4);
        s0 = snd_cnt; d0 = done_cnt;
        start_tour(4'd3);
        serve(16'h53F4, 8'hA5, "t1c0");
        serve(16'h47F1, 8'hA5, "t1c1");
        serve(16'h5BF4, 8'hA5, "t1c2");
        chk("t1.done", 32'(done), 32'd1);
        chk("t1.busy", 32'(busy), 32'd0);
        tick(); tick();
        chk("t1.sends", 32'(snd_cnt - s0), 32'd3);
        chk("t1.dones", 32'(done_cnt - d0), 32'd1);
        chk("t1.err", 32'(err), 32'd0);
        chk("t1.idx", 32'(cur_idx), 32'd2);

        // One NAK then success on cmd 0.
        load(3'd0, 16'h47F1); load(3'd1, 16'h53F4);
        s0 = snd_cnt; d0 = done_cnt;
        start_tour(4'd2);
        serve(16'h47F1, 8'h5A, "t2a");
        serve(16'h47F1, 8'hA5, "t2b");
        serve(16'h53F4, 8'hA5, "t2c");
        tick(); tick();
        chk("t2.sends", 32'(snd_cnt - s0), 32'd3);
        chk("t2.dones", 32'(done_cnt - d0), 32'd1);
        chk("t2.err", 32'(err), 32'd0);

        // Three NAKs exhaust the retries.
        s0 = snd_cnt;
        start_tour(4'd2);
        serve(16'h47F1, 8'h5A, "t2d");
        serve(16'h47F1, 8'h00, "t2e");
        serve(16'h47F1, 8'hFF, "t2f");
        chk("t2.nerr", 32'(err), 32'd1);
        chk("t2.ncode", 32'(err_code), 32'd2);
        chk("t2.nidx", 32'(cur_idx), 32'd0);
        chk("t2.nbusy", 32'(busy), 32'd0);
        tick(); tick();
        chk("t2.nsends", 32'(snd_cnt - s0), 32'd3);

        // Timeout fires on the 100th clock after cmd_snt.
        start_tour(4'd1);
        send_phase(16'h47F1, "t3a");
        repeat (99) tick();
        chk("t3.pre_err", 32'(err), 32'd0);
        chk("t3.pre_busy", 32'(busy), 32'd1);
        tick();
        chk("t3.err", 32'(err), 32'd1);
        chk("t3.code", 32'(err_code), 32'd1);
        tick();

        // Response on the expiry cycle wins.
        start_tour(4'd1);
        send_phase(16'h47F1, "t3b");
        repeat (99) tick();
        resp = 8'hA5; resp_rdy = 1'b1;
        tick();
        resp_rdy = 1'b0;
        chk("t3.edge_done", 32'(done), 32'd1);
        chk("t3.edge_err", 32'(err), 32'd0);
        tick();

        // Step mode: pause after each ack, resume by step then by clearing step_mode.
        load(3'd0, 16'h53F4); load(3'd1, 16'h47F1);
        step_mode = 1'b1;
        start_tour(4'd3);
        serve(16'h53F4, 8'hA5, "t4c0");
        chk("t4.pause0", 32'(paused), 32'd1);
        s0 = snd_cnt;
        repeat (5) tick();
        chk("t4.hold0", 32'({paused, 6'(snd_cnt - s0)}), 32'h40);
        step = 1'b1; tick(); step = 1'b0;
        serve(16'h47F1, 8'hA5, "t4c1");
        chk("t4.pause1", 32'(paused), 32'd1);
        step_mode = 1'b0; tick();
        serve(16'h5BF4, 8'hA5, "t4c2");
        chk("t4.done", 32'({done, paused}), 32'h2);
        tick();

        // Abort during WAIT_RESP of cmd 1; a later ack is ignored.
        start_tour(4'd3);
        serve(16'h53F4, 8'hA5, "t5c0");
        send_phase(16'h47F1, "t5c1");
        abort = 1'b1; tick(); abort = 1'b0;
        chk("t5.err", 32'({err, err_code}), 32'h7);
        chk("t5.busy", 32'(busy), 32'd0);
        chk("t5.idx", 32'(cur_idx), 32'd1);
        resp = 8'hA5; resp_rdy = 1'b1; tick(); resp_rdy = 1'b0;
        chk("t5.late", 32'({done, busy, err_code}), 32'h3);

        // Reset mid-tour clears every output.
        start_tour(4'd3);
        serve(16'h53F4, 8'hA5, "t5r0");
        send_phase(16'h47F1, "t5r1");
        rst = 1'b1; tick();
        chk("t5.rflags", 32'({busy, paused, done, err, err_code, snd_cmd}), 32'd0);
        chk("t5.rcmd", 32'(cmd), 32'd0);
        chk("t5.ridx", 32'(cur_idx), 32'd0);
        rst = 1'b0; tick();

        // Zero-length tour: done without any send.
        s0 = snd_cnt;
        start_tour(4'd0);
        chk("t6.zdone", 32'({done, snd_cmd}), 32'h2);
        tick(); tick();
        chk("t6.zsends", 32'(snd_cnt - s0), 32'd0);

        // start and wr_en while busy are ignored.
        start_tour(4'd3);
        serve(16'h53F4, 8'hA5, "t6c0");
        num_cmds = 4'd1; start = 1'b1; tick(); start = 1'b0;
        chk("t6.norestart", 32'(cur_idx), 32'd1);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hDEAD;
        serve(16'h47F1, 8'hA5, "t6c1");
        wr_en = 1'b0;
        serve(16'h5BF4, 8'hA5, "t6c2");
        chk("t6.done", 32'(done), 32'd1);
        tick();

        // Oversized length is clamped to DEPTH.
        for (int i = 0; i < DEPTH; i++) load(3'(i), 16'h4000 + 16'(i));
        s0 = snd_cnt;
        start_tour(4'd12);
        for (int i = 0; i < DEPTH; i++) serve(16'h4000 + 16'(i), 8'hA5, "t7");
        chk("t7.done", 32'(done), 32'd1);
        chk("t7.idx", 32'(cur_idx), 32'd7);
        tick(); tick();
        chk("t7.sends", 32'(snd_cnt - s0), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
